// File: rtl/jk_arb_pkg.sv
// Shared definitions for the JK command arbiter.
// Holds the {k,j} command encoding, the arbiter state enum and the
// next-state function of a JK element, used to predict the value the
// element should settle to after a command has been issued.
package jk_arb_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_SET  = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;
  localparam logic [1:0] CMD_TOG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Value a JK element holds after one cycle of command cmd from state cur.
  function automatic logic jk_next(input logic [1:0] cmd, input logic cur);
    logic nxt;
    case (cmd)
      CMD_HOLD: nxt = cur;
      CMD_SET:  nxt = 1'b1;
      CMD_CLR:  nxt = 1'b0;
      CMD_TOG:  nxt = ~cur;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_rr_pick.sv
// Round-robin picker (purely combinational).
// Ports:
//   req    - per-requester request vector
//   rr_ptr - index where the search starts (always < NREQ)
//   valid  - at least one request is asserted
//   idx    - first asserted request at or above rr_ptr, wrapping to 0
module jk_rr_pick
  import jk_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int pos;

  // Scan NREQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = {IW{1'b0}};
    pos   = 0;
    for (int off = 0; off < NREQ; off++) begin
      // rr_ptr + off never exceeds 2*NREQ-2, so one subtraction wraps it.
      pos = int'(rr_ptr) + off;
      pos = (pos >= NREQ) ? (pos - NREQ) : pos;
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = IW'(pos);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter sharing one JK state element among NREQ requesters.
// A granted command is driven on j/k for one cycle, the element is given
// WAIT_CYC cycles to settle, and the captured value is returned with an
// error flag if it differs from the predicted result.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   req, cmd         - per-requester request and {k,j} command (2 bits each)
//   gnt              - one-hot grant, high during the issue cycle
//   done             - one-cycle response pulse
//   rsp_id           - requester served by the last response
//   rsp_state, err   - captured element value and mismatch flag
//   j, k, fsm_out    - drive to and state from the JK element
module jk_cmd_arbiter
  import jk_arb_pkg::*;
#(
  parameter  int NREQ     = 2,
  parameter  int WAIT_CYC = 1,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [IW-1:0]     rsp_id,
  output logic              rsp_state,
  output logic              err,
  output logic              j,
  output logic              k,
  input  logic              fsm_out
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic [1:0]    cmd_q;
  logic          expected;
  logic [CW-1:0] cnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [1:0]    pick_cmd;

  jk_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign pick_cmd = cmd[{pick_idx, 1'b0} +: 2];

  // Transaction sequencer; every output is a register updated on entry to
  // the state that owns it, so outputs change only on a clock edge or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= {IW{1'b0}};
      idx       <= {IW{1'b0}};
      cmd_q     <= CMD_HOLD;
      expected  <= 1'b0;
      cnt       <= {CW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      done      <= 1'b0;
      rsp_id    <= {IW{1'b0}};
      rsp_state <= 1'b0;
      err       <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx   <= pick_idx;
            cmd_q <= pick_cmd;
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            j     <= pick_cmd[0];
            k     <= pick_cmd[1];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // fsm_out still shows the pre-command value during this cycle.
          expected <= jk_next(cmd_q, fsm_out);
          cnt      <= CW'(WAIT_CYC - 1);
          gnt      <= {NREQ{1'b0}};
          j        <= 1'b0;
          k        <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == {CW{1'b0}}) begin
            rsp_state <= fsm_out;
            err       <= (fsm_out != expected);
            rsp_id    <= idx;
            done      <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          done   <= 1'b0;
          rr_ptr <= (idx == IW'(NREQ - 1)) ? {IW{1'b0}} : (idx + IW'(1));
          state  <= IDLE;
        end
        default: begin
          gnt   <= {NREQ{1'b0}};
          done  <= 1'b0;
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
